// File: rtl/nn_config_loader.sv
// -----------------------------------------------------------------------------
// nn_config_loader
//
// Streaming configuration initiator for the fully-connected accelerator.
// Consumes a packed 32-bit word stream of neuron records (header, N weights,
// one bias word) and drives the shared neuron configuration bus. Headers are
// validated, records are sequenced, and completion or error is reported.
//
// Header word: [7:0] layer, [15:8] neuron, [31:16] weight count N.
// A header with N == 0 marks the end of the stream.
//
// Optional feature macro: NN_LOADER_CHECKSUM_EN
//   When defined, a running XOR of every accepted word (first header through
//   end marker) is kept. One extra word follows the end marker. If it matches
//   the XOR the loader finishes cleanly, otherwise it enters the error state.
//
// Ports:
//   clk               in   clock
//   rst               in   synchronous active-high reset
//   start             in   arm loader (honoured only in IDLE or ERR)
//   s_data[31:0]      in   stream word
//   s_valid           in   stream word valid
//   s_ready           out  loader accepts word (transfer on s_valid & s_ready)
//   weightValid       out  one-cycle strobe per weight word
//   weightValue[31:0] out  weight word, held between strobes
//   biasValid         out  one-cycle strobe per bias word
//   biasValue[31:0]   out  bias word, held between strobes
//   config_layer_num  out  target layer, zero-extended
//   config_neuron_num out  target neuron, zero-extended
//   busy              out  high while a stream is being consumed
//   done              out  one-cycle pulse on clean end of stream
//   error             out  sticky until start or reset
//   neuronCount[15:0] out  records completed since last start (saturating)
// -----------------------------------------------------------------------------
module nn_config_loader #(
  parameter int maxLayers  = 4,
  parameter int maxNeurons = 30,
  parameter int maxWeight  = 784
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic        weightValid,
  output logic [31:0] weightValue,
  output logic        biasValid,
  output logic [31:0] biasValue,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] neuronCount
);

  localparam logic [7:0]  MAX_LAYERS  = 8'(maxLayers);
  localparam logic [7:0]  MAX_NEURONS = 8'(maxNeurons);
  localparam logic [15:0] MAX_WEIGHT  = 16'(maxWeight);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WGT,
    BIAS,
`ifdef NN_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] remaining_q, remaining_d;
  logic [7:0]  layer_q, layer_d;
  logic [7:0]  neuron_q, neuron_d;
  logic [31:0] weight_value_q, weight_value_d;
  logic [31:0] bias_value_q, bias_value_d;
  logic        weight_valid_q, weight_valid_d;
  logic        bias_valid_q, bias_valid_d;
  logic [15:0] count_q, count_d;
`ifdef NN_LOADER_CHECKSUM_EN
  logic [31:0] xor_q, xor_d;
`endif

  logic [7:0]  hdr_layer;
  logic [7:0]  hdr_neuron;
  logic [15:0] hdr_count;
  logic        hdr_illegal;
  logic        accept;

  assign hdr_layer   = s_data[7:0];
  assign hdr_neuron  = s_data[15:8];
  assign hdr_count   = s_data[31:16];
  assign hdr_illegal = (hdr_layer == 8'd0) || (hdr_layer > MAX_LAYERS) ||
                       (hdr_neuron >= MAX_NEURONS) || (hdr_count > MAX_WEIGHT);

  // Ready and status are pure decodes of the registered state, so they never
  // depend combinationally on s_valid.
  always_comb begin
    s_ready = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      HDR, WGT, BIAS: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
`ifdef NN_LOADER_CHECKSUM_EN
      CHK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign accept = s_valid & s_ready;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    layer_d        = layer_q;
    neuron_d       = neuron_q;
    weight_value_d = weight_value_q;
    bias_value_d   = bias_value_q;
    weight_valid_d = 1'b0;
    bias_valid_d   = 1'b0;
    count_d        = count_q;
`ifdef NN_LOADER_CHECKSUM_EN
    xor_d          = xor_q;
`endif
    unique case (state_q)
      IDLE, ERR: begin
        if (start) begin
          state_d = HDR;
          count_d = 16'd0;
`ifdef NN_LOADER_CHECKSUM_EN
          xor_d   = 32'd0;
`endif
        end
      end
      HDR: begin
        if (accept) begin
`ifdef NN_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ s_data;
`endif
          // End marker is recognised before any field validation.
          if (hdr_count == 16'd0) begin
`ifdef NN_LOADER_CHECKSUM_EN
            state_d = CHK;
`else
            state_d = DONE;
`endif
          end else if (hdr_illegal) begin
            state_d = ERR;
          end else begin
            layer_d     = hdr_layer;
            neuron_d    = hdr_neuron;
            remaining_d = hdr_count;
            state_d     = WGT;
          end
        end
      end
      WGT: begin
        if (accept) begin
`ifdef NN_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ s_data;
`endif
          weight_value_d = s_data;
          weight_valid_d = 1'b1;
          remaining_d    = remaining_q - 16'd1;
          if (remaining_q == 16'd1) state_d = BIAS;
        end
      end
      BIAS: begin
        if (accept) begin
`ifdef NN_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ s_data;
`endif
          bias_value_d = s_data;
          bias_valid_d = 1'b1;
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
          state_d = HDR;
        end
      end
`ifdef NN_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept) state_d = (s_data == xor_q) ? DONE : ERR;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      remaining_q    <= 16'd0;
      layer_q        <= 8'd0;
      neuron_q       <= 8'd0;
      weight_value_q <= 32'd0;
      bias_value_q   <= 32'd0;
      weight_valid_q <= 1'b0;
      bias_valid_q   <= 1'b0;
      count_q        <= 16'd0;
`ifdef NN_LOADER_CHECKSUM_EN
      xor_q          <= 32'd0;
`endif
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      layer_q        <= layer_d;
      neuron_q       <= neuron_d;
      weight_value_q <= weight_value_d;
      bias_value_q   <= bias_value_d;
      weight_valid_q <= weight_valid_d;
      bias_valid_q   <= bias_valid_d;
      count_q        <= count_d;
`ifdef NN_LOADER_CHECKSUM_EN
      xor_q          <= xor_d;
`endif
    end
  end

  assign weightValid       = weight_valid_q;
  assign weightValue       = weight_value_q;
  assign biasValid         = bias_valid_q;
  assign biasValue         = bias_value_q;
  assign config_layer_num  = {24'd0, layer_q};
  assign config_neuron_num = {24'd0, neuron_q};
  assign done              = (state_q == DONE);
  assign error             = (state_q == ERR);
  assign neuronCount       = count_q;

endmodule

// File: tb/tb_nn_config_loader.sv
// -----------------------------------------------------------------------------
// tb_nn_config_loader
//
// Directed bench for nn_config_loader. Expected weight/bias strobes (value,
// layer, neuron) are queued as words are driven and compared by a monitor as
// the strobes appear. Status outputs are compared inline after each step.
// Build with NN_LOADER_CHECKSUM_EN defined to exercise the checksum word.
// -----------------------------------------------------------------------------
module tb_nn_config_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        weightValid;
  logic [31:0] weightValue;
  logic        biasValid;
  logic [31:0] biasValue;
  logic [31:0] config_layer_num;
  logic [31:0] config_neuron_num;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] neuronCount;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    logic        is_bias;
    logic [31:0] value;
    logic [31:0] layer;
    logic [31:0] neuron;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] tb_xor;

  nn_config_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .s_data            (s_data),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .weightValid       (weightValid),
    .weightValue       (weightValue),
    .biasValid         (biasValid),
    .biasValue         (biasValue),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .done              (done),
    .error             (error),
    .neuronCount       (neuronCount)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (weightValid || biasValid) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe", {30'd0, biasValid, weightValid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", {30'd0, biasValid, weightValid},
              e.is_bias ? 32'd2 : 32'd1);
        check(e.is_bias ? "bias_value" : "weight_value",
              e.is_bias ? biasValue : weightValue, e.value);
        check("strobe_layer", config_layer_num, e.layer);
        check("strobe_neuron", config_neuron_num, e.neuron);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // kind: 0 = no strobe expected, 1 = weight strobe, 2 = bias strobe.
  task automatic send_word(input logic [31:0] w, input int kind, input int max_gap);
    int budget;
    repeat ($urandom_range(0, max_gap)) begin
      s_valid = 1'b0;
      s_data  = $urandom;
      step();
    end
    s_valid = 1'b1;
    s_data  = w;
    tb_xor  = tb_xor ^ w;
    budget  = 0;
    while (!s_ready && budget < 50) begin
      step();
      budget++;
    end
    if (!s_ready) begin
      check("ready_timeout", {31'd0, s_ready}, 32'd1);
      s_valid = 1'b0;
    end else begin
      step();
      s_valid = 1'b0;
      check("weight_strobe_latency", {31'd0, weightValid}, (kind == 1) ? 32'd1 : 32'd0);
      check("bias_strobe_latency", {31'd0, biasValid}, (kind == 2) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic send_record(input int l, input int n, input int cnt,
                             input logic [31:0] base, input logic [31:0] bias,
                             input int max_gap);
    exp_t e;
    send_word({16'(cnt), 8'(n), 8'(l)}, 0, max_gap);
    check("hdr_layer", config_layer_num, 32'(l));
    check("hdr_neuron", config_neuron_num, 32'(n));
    for (int i = 0; i < cnt; i++) begin
      e = '{1'b0, base + 32'(i), 32'(l), 32'(n)};
      sb.push_back(e);
      send_word(base + 32'(i), 1, max_gap);
    end
    e = '{1'b1, bias, 32'(l), 32'(n)};
    sb.push_back(e);
    send_word(bias, 2, max_gap);
  endtask

  task automatic end_stream(input logic ok);
    logic [31:0] ck;
    send_word(32'd0, 0, 0);
`ifdef NN_LOADER_CHECKSUM_EN
    check("chk_no_early_done", {31'd0, done}, 32'd0);
    ck = tb_xor;
    send_word(ok ? ck : (ck ^ 32'd1), 0, 0);
`else
    ck = 32'd0;
`endif
    check("end_done", {31'd0, done}, {31'd0, ok});
    check("end_error", {31'd0, error}, {31'd0, !ok});
    step();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("end_ready_low", {31'd0, s_ready}, 32'd0);
    check("end_busy_low", {31'd0, busy}, 32'd0);
  endtask

  task automatic do_start();
    start  = 1'b1;
    tb_xor = 32'd0;
    step();
    start  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, {31'd0, s_ready}, 32'd0);
    check({tag, "_wvalid"}, {31'd0, weightValid}, 32'd0);
    check({tag, "_bvalid"}, {31'd0, biasValid}, 32'd0);
    check({tag, "_wvalue"}, weightValue, 32'd0);
    check({tag, "_bvalue"}, biasValue, 32'd0);
    check({tag, "_layer"}, config_layer_num, 32'd0);
    check({tag, "_neuron"}, config_neuron_num, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_error"}, {31'd0, error}, 32'd0);
    check({tag, "_count"}, {16'd0, neuronCount}, 32'd0);
  endtask

  initial begin
    int c0;
    logic [31:0] bad_hdr[4];

    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 32'd0; tb_xor = 32'd0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle");

    // Single record L3 N4, 10 weights 1..10, bias 0x51.
    do_start();
    check("armed_busy", {31'd0, busy}, 32'd1);
    send_record(3, 4, 10, 32'd1, 32'h51, 0);
    check("rec1_count", {16'd0, neuronCount}, 32'd1);
    check("rec1_layer_hold", config_layer_num, 32'd3);
    end_stream(1'b1);

    // Two back-to-back records at full rate: 8 accepted words in 8 cycles.
    do_start();
    check("start_clears_count", {16'd0, neuronCount}, 32'd0);
    c0 = cyc;
    send_record(1, 0, 2, 32'hA0, 32'hB0, 0);
    check("rec_a_neuron_hold", config_neuron_num, 32'd0);
    send_record(1, 1, 2, 32'hC0, 32'hD0, 0);
    check("no_bubble_cycles", 32'(cyc - c0), 32'd8);
    check("two_rec_count", {16'd0, neuronCount}, 32'd2);
    end_stream(1'b1);

    // Illegal headers: N too large, layer 0, layer too high, neuron too high.
    bad_hdr[0] = {16'd785, 8'd0, 8'd1};
    bad_hdr[1] = {16'd3, 8'd0, 8'd0};
    bad_hdr[2] = {16'd3, 8'd0, 8'd5};
    bad_hdr[3] = {16'd3, 8'd30, 8'd1};
    for (int i = 0; i < 4; i++) begin
      do_start();
      check("err_cleared_by_start", {31'd0, error}, 32'd0);
      send_word(bad_hdr[i], 0, 0);
      check("bad_hdr_error", {31'd0, error}, 32'd1);
      check("bad_hdr_ready", {31'd0, s_ready}, 32'd0);
      check("bad_hdr_layer_kept", config_layer_num, 32'd1);
      check("bad_hdr_neuron_kept", config_neuron_num, 32'd1);
      s_valid = 1'b1;
      s_data  = 32'h0001_0101;
      step();
      step();
      s_valid = 1'b0;
      check("err_sticky", {31'd0, error}, 32'd1);
    end
    do_start();
    check("reload_error", {31'd0, error}, 32'd0);
    check("reload_count", {16'd0, neuronCount}, 32'd0);
    send_record(2, 7, 3, 32'h100, 32'h200, 0);
    end_stream(1'b1);

    // Legal boundary record with randomly toggled s_valid.
    do_start();
    send_record(4, 29, 5, 32'hDEAD_0000, 32'hBEEF, 2);
    check("rand_count", {16'd0, neuronCount}, 32'd1);
    end_stream(1'b1);

    // Largest legal weight count.
    do_start();
    send_record(1, 2, 784, 32'h5000, 32'h6000, 0);
    end_stream(1'b1);

    // Reset after 3 of 10 weights.
    do_start();
    send_word({16'd10, 8'd5, 8'd2}, 0, 0);
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{1'b0, 32'h70 + 32'(i), 32'd2, 32'd5});
      send_word(32'h70 + 32'(i), 1, 0);
    end
    rst = 1'b1;
    step();
    check_all_zero("mid_reset");
    rst = 1'b0;
    step();
    check("post_reset_ready", {31'd0, s_ready}, 32'd0);

`ifdef NN_LOADER_CHECKSUM_EN
    // Bad checksum: error, no done.
    do_start();
    send_record(3, 4, 4, 32'h11, 32'h99, 0);
    end_stream(1'b0);
    check("bad_ck_error_sticky", {31'd0, error}, 32'd1);
`endif

    step();
    step();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/nn_config_loader.md
# nn_config_loader

Streaming configuration initiator for the fully-connected accelerator. Consumes a packed 32-bit word stream (from DMA/AXI-stream front end) and drives the shared neuron configuration bus (`weightValid`, `biasValid`, `weightValue`, `biasValue`, `config_layer_num`, `config_neuron_num`) that every neuron instance decodes. Each neuron record is a header, the weights, then one bias word. The loader validates headers, sequences the records and reports completion or error to the control block.

## Interface
Parameters:
- `maxLayers`, 4, highest legal layer number; legal layers are 1..maxLayers.
- `maxNeurons`, 30, neuron numbers 0..maxNeurons-1 are legal.
- `maxWeight`, 784, largest legal weight count per neuron.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  arm loader; honoured only in IDLE or ERR.
- `s_data`  in  32  stream word.
- `s_valid`  in  1  stream word valid.
- `s_ready`  out  1  loader accepts word; transfer when `s_valid & s_ready`.
- `weightValid`  out  1  one-cycle strobe per weight word.
- `weightValue`  out  32  weight word.
- `biasValid`  out  1  one-cycle strobe per bias word.
- `biasValue`  out  32  bias word.
- `config_layer_num`  out  32  target layer, zero-extended.
- `config_neuron_num`  out  32  target neuron, zero-extended.
- `busy`  out  1  high in HDR/WGT/BIAS/CHK.
- `done`  out  1  one-cycle pulse on clean end of stream.
- `error`  out  1  sticky until `start` or reset.
- `neuronCount`  out  16  records completed since last `start`.

## Operation
- Header word: [7:0] layer, [15:8] neuron, [31:16] weight count N.
- N==0 header is the end marker.
- States:
  - IDLE: `s_ready`=0. `start` -> HDR; clear `neuronCount`, `error`.
  - HDR: accept header.
    - N==0 -> CHK if macro defined, else DONE.
    - layer 0 or >maxLayers, neuron >= maxNeurons, or N>maxWeight -> ERR.
    - Otherwise latch layer/neuron onto config outputs, load remaining-count = N -> WGT.
  - WGT: each accepted word -> `weightValue`, `weightValid`; decrement remaining. Last weight -> BIAS.
  - BIAS: accepted word -> `biasValue`, `biasValid`; `neuronCount`+1 -> HDR.
  - DONE: one cycle, `done`=1 -> IDLE.
  - ERR: `s_ready`=0, `error`=1. `start` -> HDR, clears `error` and `neuronCount`.
- `s_ready`=1 in HDR, WGT, BIAS, CHK; 0 elsewhere.
- `config_layer_num`/`config_neuron_num` change only on a legal non-end header. They hold through the following bias strobe and until the next legal header.
- `weightValue`/`biasValue` hold their last value when not strobed.
- `neuronCount` saturates at 16'hFFFF.
- `s_valid` low stalls any state without losing position. Gaps between weights are legal; the neuron side increments its address only on the strobe.

## Timing
- Reset: state IDLE; all outputs 0, including data, config nums, `neuronCount`, `error`.
- Latency: word accepted at edge k -> strobe high during cycle k+1 (registered). Config nums are valid from the cycle after header acceptance, so they are valid before the first weight strobe.
- Throughput: one word per cycle with no bubble between records. Header, N weights and bias take N+2 cycles at full rate.
- End marker accepted at edge k: `done` high in cycle k+1 (no macro) or one cycle after the checksum word (macro).
- `start` while busy is ignored.
- `rst` mid-record aborts immediately. Strobes are low next cycle and no partial record is flagged.
- An illegal header produces no strobes and does not change the config nums.

## Configuration
- `NN_LOADER_CHECKSUM_EN` defined:
  - A running XOR accumulates every accepted word from the first header through the end marker, cleared on `start`.
  - In CHK, one more word is accepted. If it equals the XOR -> DONE; otherwise -> ERR, `done` not pulsed.
- Undefined: the end marker goes directly to DONE. No CHK state and no accumulator are built.

## Test plan
- Header layer=3, neuron=4, N=10, weights 1..10, bias 0x51, end marker -> ten `weightValid` strobes with values 1..10 in order, then `biasValid` with 0x51, config nums 3/4 throughout, `neuronCount`=1, `done` one cycle after end.
- Two back-to-back records (L1 N0, L1 N1, N=2), `s_valid` held high -> 8 cycles accepted, no bubbles, config nums switch 0->1 exactly at second header, `neuronCount`=2.
- Header with N=785 -> `error`=1, `s_ready`=0, no strobes, config nums unchanged; `start` clears `error` and reloads cleanly.
- Randomly toggled `s_valid` over an N=5 record -> exactly 5 weight strobes plus 1 bias strobe, order preserved.
- `rst` asserted after 3 of 10 weights -> all outputs 0 next cycle, IDLE, `s_ready`=0.
- Macro on: stream with correct XOR word -> `done`. Same stream with XOR^1 -> `error`=1 and no `done`.
